// File: rtl/signal_phase_sequencer.sv
// Traffic signal phase sequencer: four approaches served in turn, each phase a
// countdown followed by an all-red clearance, with a dark night mode.
module signal_phase_sequencer #(
  parameter int unsigned PHASE_TIME = 20,
  parameter int unsigned CLEAR_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       hold,
  input  logic       night_mode,
  output logic [4:0] Count_out,
  output logic [1:0] signal_Pos,
  output logic       signal,
  output logic       light_out_time,
  output logic       phase_done
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    DARK  = 2'd2
  } state_t;

  localparam logic [4:0] PHASE_LOAD = 5'(PHASE_TIME);
  localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_TIME);

  state_t     state, state_nxt;
  logic [3:0] clr_cnt, clr_nxt;
  logic [4:0] count_nxt;
  logic [1:0] pos_nxt;
  logic       sig_nxt, light_nxt, done_nxt;
  logic       eff_tick;

  // hold beats tick; in DARK the raw tick is used instead.
  assign eff_tick = tick & ~hold;

  // NOTE: every variable gets its default before the case so that paths
  // which do not assign it hold the register value instead of inferring a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = Count_out;
    clr_nxt   = clr_cnt;
    pos_nxt   = signal_Pos;
    sig_nxt   = signal;
    light_nxt = light_out_time;
    done_nxt  = 1'b0;

    case (state)
      RUN: begin
        if (eff_tick) begin
          sig_nxt = ~signal;
          if (Count_out != 5'd0) begin
            count_nxt = Count_out - 5'd1;
          end else begin
            state_nxt = CLEAR;
            clr_nxt   = CLEAR_LOAD;
          end
        end
      end

      CLEAR: begin
        if (eff_tick) begin
          sig_nxt = ~signal;
          if (clr_cnt > 4'd1) begin
            clr_nxt = clr_cnt - 4'd1;
          end else begin
            // Exit tick: night_mode is only sampled here.
            clr_nxt  = 4'd0;
            done_nxt = 1'b1;
            if (night_mode) begin
              state_nxt = DARK;
              pos_nxt   = 2'd0;
              count_nxt = 5'd0;
              light_nxt = 1'b1;
              sig_nxt   = 1'b0;
            end else begin
              state_nxt = RUN;
              pos_nxt   = signal_Pos + 2'd1;
              count_nxt = PHASE_LOAD;
            end
          end
        end
      end

      DARK: begin
        sig_nxt   = 1'b0;
        light_nxt = 1'b1;
        if (tick && !night_mode) begin
          state_nxt = RUN;
          pos_nxt   = 2'd0;
          count_nxt = PHASE_LOAD;
          light_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = RUN;
        count_nxt = PHASE_LOAD;
        clr_nxt   = 4'd0;
        pos_nxt   = 2'd0;
        sig_nxt   = 1'b0;
        light_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      Count_out      <= PHASE_LOAD;
      clr_cnt        <= 4'd0;
      signal_Pos     <= 2'd0;
      signal         <= 1'b0;
      light_out_time <= 1'b0;
      phase_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      Count_out      <= count_nxt;
      clr_cnt        <= clr_nxt;
      signal_Pos     <= pos_nxt;
      signal         <= sig_nxt;
      light_out_time <= light_nxt;
      phase_done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_signal_phase_sequencer.sv
// Scoreboard bench for signal_phase_sequencer: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares after each clock edge.
module tb_signal_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
  logic       night_mode = 1'b0;
  logic [4:0] Count_out;
  logic [1:0] signal_Pos;
  logic       signal;
  logic       light_out_time;
  logic       phase_done;

  signal_phase_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .hold           (hold),
    .night_mode     (night_mode),
    .Count_out      (Count_out),
    .signal_Pos     (signal_Pos),
    .signal         (signal),
    .light_out_time (light_out_time),
    .phase_done     (phase_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    chk;
    string name;
    int    count;
    int    pos;
    int    sig;
    int    light;
    int    done;
  } exp_t;

  exp_t sb[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   sig_toggles = 0;
  int   done_cnt    = 0;
  logic prev_sig    = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: one sample per cycle, just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (signal !== prev_sig) sig_toggles++;
      prev_sig = signal;
      if (phase_done === 1'b1) done_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check({e.name, ".count"}, int'(Count_out), e.count);
          check({e.name, ".pos"},   int'(signal_Pos), e.pos);
          check({e.name, ".sig"},   int'(signal), e.sig);
          check({e.name, ".light"}, int'(light_out_time), e.light);
          check({e.name, ".done"},  int'(phase_done), e.done);
        end
      end
    end
  end

  task automatic cyc(input logic t, input logic h, input logic nm);
    exp_t e;
    @(negedge clk);
    tick = t; hold = h; night_mode = nm;
    e.chk = 0; e.name = "";
    e.count = 0; e.pos = 0; e.sig = 0; e.light = 0; e.done = 0;
    sb.push_back(e);
  endtask

  task automatic cyc_chk(input logic t, input logic h, input logic nm, input string name,
                         input int c, input int p, input int s, input int l, input int d);
    exp_t e;
    @(negedge clk);
    tick = t; hold = h; night_mode = nm;
    e.chk = 1; e.name = name;
    e.count = c; e.pos = p; e.sig = s; e.light = l; e.done = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0; hold = 1'b0; night_mode = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sig_toggles = 0;
    done_cnt    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int d0;

    // Reset state, stable without ticks.
    do_reset();
    for (int i = 0; i < 3; i++) cyc_chk(0, 0, 0, "idle", 20, 0, 0, 0, 0);

    // One full phase: 20 countdown, 1 into clear, 2 clear ticks.
    for (int i = 1; i <= 23; i++) begin
      c = (i <= 20) ? 20 - i : ((i == 23) ? 20 : 0);
      cyc_chk(1, 0, 0, $sformatf("phase1_t%0d", i), c, (i == 23) ? 1 : 0, i % 2, 0,
              (i == 23) ? 1 : 0);
    end
    cyc_chk(0, 0, 0, "phase1_after", 20, 1, 1, 0, 0);
    @(negedge clk);
    check("phase1_toggles", sig_toggles, 23);
    check("phase1_done_pulses", done_cnt, 1);

    // Four phases: approach index wraps 3 -> 0.
    do_reset();
    for (int i = 1; i <= 92; i++) begin
      if (i % 23 == 0)
        cyc_chk(1, 0, 0, $sformatf("rot_t%0d", i), 20, (i / 23) % 4, i % 2, 0, 1);
      else
        cyc(1, 0, 0);
    end
    cyc_chk(0, 0, 0, "rot_after", 20, 0, 0, 0, 0);
    @(negedge clk);
    check("rot_done_pulses", done_cnt, 4);
    check("rot_toggles", sig_toggles, 92);

    // Hold freezes count and blink, including tick=hold=1.
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1, 0, 0);
    cyc_chk(1, 0, 0, "hold_pre", 10, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      cyc_chk((k % 2 == 0) ? 1'b1 : 1'b0, 1, 0, $sformatf("hold_k%0d", k), 10, 0, 0, 0, 0);
    cyc_chk(1, 0, 0, "hold_release", 9, 0, 1, 0, 0);
    cyc(0, 0, 0);

    // Night request raised at count 15 only takes effect at clearance exit.
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0);
    cyc_chk(1, 0, 0, "night_pre", 15, 0, 1, 0, 0);
    for (int i = 6; i <= 22; i++)
      cyc_chk(1, 0, 1, $sformatf("night_t%0d", i), (i <= 20) ? 20 - i : 0, 0, i % 2, 0, 0);
    cyc_chk(1, 0, 1, "night_enter", 0, 0, 0, 1, 1);
    cyc_chk(1, 0, 1, "dark_stay", 0, 0, 0, 1, 0);
    cyc_chk(0, 0, 0, "dark_notick", 0, 0, 0, 1, 0);
    cyc_chk(1, 1, 0, "dark_exit_hold_ignored", 20, 0, 0, 0, 0);
    cyc_chk(0, 0, 0, "dark_exit_after", 20, 0, 0, 0, 0);

    // Asynchronous reset during clearance on approach 2.
    do_reset();
    for (int i = 1; i <= 66; i++) cyc(1, 0, 0);
    cyc_chk(1, 0, 0, "clear_pos2", 0, 2, 1, 0, 0);
    @(posedge clk);
    #4;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("async_rst.count", int'(Count_out), 20);
    check("async_rst.pos",   int'(signal_Pos), 0);
    check("async_rst.sig",   int'(signal), 0);
    check("async_rst.light", int'(light_out_time), 0);
    check("async_rst.done",  int'(phase_done), 0);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("async_rst_no_pulse", done_cnt, d0);
    cyc_chk(0, 0, 0, "post_rst_idle", 20, 0, 0, 0, 0);
    cyc_chk(1, 0, 0, "post_rst_tick", 19, 0, 1, 0, 0);
    cyc(0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_phase_sequencer.md
SIGNAL_PHASE_SEQUENCER -- requirements
Module: signal_phase_sequencer

Interface
REQ-001 Parameter PHASE_TIME, default 20, countdown start value per phase; legal range 1..31.
REQ-002 Parameter CLEAR_TIME, default 2, all-red clearance length in ticks; legal range 1..15.
REQ-003 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port tick  input  1  one-second enable; each clk cycle with tick=1 SHALL count as one tick.
REQ-006 Port hold  input  1  freeze request; 1 SHALL suppress tick effects in RUN and CLEAR.
REQ-007 Port night_mode  input  1  night request; 1 SHALL select dark operation at the next phase boundary.
REQ-008 Port Count_out  output  5  remaining seconds of the current phase.
REQ-009 Port signal_Pos  output  2  active approach index 0..3.
REQ-010 Port signal  output  1  blink clock for pedestrian warning lamps.
REQ-011 Port light_out_time  output  1  1 while in dark/night operation.
REQ-012 Port phase_done  output  1  one-clk pulse on each phase advance.
REQ-013 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Function
REQ-014 The FSM SHALL have exactly three states: RUN, CLEAR, DARK.
REQ-015 In RUN, an effective tick (tick=1, hold=0) with Count_out>0 SHALL decrement Count_out by 1.
REQ-016 In RUN, an effective tick with Count_out=0 SHALL enter CLEAR, load the clearance counter with CLEAR_TIME, and hold Count_out=0.
REQ-017 In CLEAR, each effective tick SHALL decrement the clearance counter; signal_Pos SHALL be unchanged.
REQ-018 An effective tick in CLEAR with clearance counter=1 and night_mode=0 SHALL enter RUN, set signal_Pos to signal_Pos+1 mod 4 (3 wraps to 0), reload Count_out=PHASE_TIME, and assert phase_done for exactly that one clk.
REQ-019 An effective tick in CLEAR with clearance counter=1 and night_mode=1 SHALL enter DARK, set signal_Pos=0, Count_out=0, light_out_time=1, and assert phase_done for one clk.
REQ-020 In DARK, light_out_time SHALL stay 1 and signal SHALL stay 0; hold SHALL be ignored.
REQ-021 In DARK, a tick with night_mode=0 SHALL enter RUN with signal_Pos=0, Count_out=PHASE_TIME, light_out_time=0, and phase_done=0.
REQ-022 Full phase period SHALL be PHASE_TIME+1+CLEAR_TIME effective ticks (23 at defaults).
REQ-023 In RUN and CLEAR, signal SHALL toggle on every effective tick.
REQ-024 tick and hold both 1 in the same cycle: hold SHALL win; no count, toggle, or state change.
REQ-025 night_mode changes in RUN or mid-CLEAR SHALL have no effect until the CLEAR exit tick.
REQ-026 Counters SHALL never underflow or wrap; Count_out SHALL never exceed PHASE_TIME.
REQ-027 phase_done SHALL be 0 in every cycle other than those listed in REQ-018 and REQ-019.

Reset
REQ-028 While rst=1, outputs SHALL be forced immediately, without waiting for clk: state=RUN, Count_out=PHASE_TIME, signal_Pos=0, signal=0, light_out_time=0, phase_done=0, clearance counter=0.
REQ-029 Reset asserted mid-operation (any state, including DARK) SHALL abort that state; after release, operation SHALL restart per REQ-028 on the next effective tick.

Verification
REQ-030 Assert rst, release; no tick -> Count_out=20, signal_Pos=0, signal=0, light_out_time=0, phase_done=0, all stable.
REQ-031 From reset, apply 23 single-cycle ticks -> Count_out reaches 0 at tick 20, CLEAR at tick 21, signal_Pos=1, Count_out=20, and a one-clk phase_done at tick 23; signal has toggled 23 times.
REQ-032 Apply 92 ticks from reset -> signal_Pos sequence 0,1,2,3,0 with 4 phase_done pulses; signal_Pos=0 and Count_out=20 at the end.
REQ-033 At Count_out=10, hold=1 for 5 ticks, including one cycle with tick=hold=1 -> Count_out stays 10 and signal does not toggle; hold=0 plus 1 tick -> Count_out=9.
REQ-034 night_mode=1 asserted at Count_out=15 -> DARK is entered only at the CLEAR exit tick (light_out_time=1, signal_Pos=0, Count_out=0); night_mode=0 plus 1 tick -> RUN, Count_out=20, light_out_time=0.
REQ-035 Assert rst asynchronously, between clk edges, during CLEAR with signal_Pos=2 -> outputs go to the REQ-028 values before the next clk edge; no phase_done pulse.
